// File: rtl/spi_arbiter_if.sv
// Handshake bundle between the requesters, the arbiter and the SPI master.
// The master modport is the arbiter's view; slave is the environment's view.
interface spi_arbiter_if #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned CMD_WIDTH  = 12,
  parameter int unsigned READ_WIDTH = 8
);
  logic [N_REQ*CMD_WIDTH-1:0] req_cmd;
  logic [N_REQ-1:0]           req_vld;
  logic [N_REQ-1:0]           req_rdy;
  logic [N_REQ-1:0]           rsp_vld;
  logic [READ_WIDTH-1:0]      rsp_data;
  logic                       rsp_err;
  logic [CMD_WIDTH-1:0]       m_cmd;
  logic                       m_cmd_vld;
  logic                       m_cmd_rdy;
  logic                       m_done;
  logic                       m_rd_vld;
  logic [READ_WIDTH-1:0]      m_rd_data;
  logic                       busy;

  modport master (
    input  req_cmd, req_vld, m_cmd_rdy, m_done, m_rd_vld, m_rd_data,
    output req_rdy, rsp_vld, rsp_data, rsp_err, m_cmd, m_cmd_vld, busy
  );

  modport slave (
    output req_cmd, req_vld, m_cmd_rdy, m_done, m_rd_vld, m_rd_data,
    input  req_rdy, rsp_vld, rsp_data, rsp_err, m_cmd, m_cmd_vld, busy
  );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter funnelling N_REQ command requesters onto one SPI master,
// one outstanding transaction at a time, with a WAIT-state timeout.
module spi_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned CMD_WIDTH  = 12,
  parameter int unsigned READ_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_arbiter_if.master bus
);
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, GRANT, ISSUE, WAIT, RESP} state_t;

  state_t               state;
  logic [IDX_W-1:0]     gnt_idx;
  logic [IDX_W-1:0]     last;
  logic [IDX_W-1:0]     win_idx;
  logic [CMD_WIDTH-1:0] cmd_reg;
  logic [CMD_WIDTH-1:0] win_cmd;
  logic [CNT_W-1:0]     cnt;
  logic                 is_rd;
  logic                 wait_done;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    return N_REQ'(1) << i;
  endfunction

  // Search from last+1 upward with wrap; the descending loop lets the nearest candidate win.
  always_comb begin
    win_idx = last;
    for (int k = int'(N_REQ); k >= 1; k--) begin
      if (bus.req_vld[(int'(last) + k) % int'(N_REQ)]) begin
        win_idx = IDX_W'((int'(last) + k) % int'(N_REQ));
      end
    end
    win_cmd = bus.req_cmd[win_idx*CMD_WIDTH +: CMD_WIDTH];
  end

  assign is_rd     = cmd_reg[CMD_WIDTH-1];
  assign wait_done = is_rd ? bus.m_rd_vld : bus.m_done;

  // rsp_data/rsp_err double as the data and error registers: loaded on entry to RESP, cleared on exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      gnt_idx       <= '0;
      last          <= IDX_W'(N_REQ - 1);
      cmd_reg       <= '0;
      cnt           <= '0;
      bus.req_rdy   <= '0;
      bus.rsp_vld   <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
      bus.m_cmd     <= '0;
      bus.m_cmd_vld <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req_vld) begin
            gnt_idx     <= win_idx;
            last        <= win_idx;
            cmd_reg     <= win_cmd;
            bus.req_rdy <= onehot(win_idx);
            bus.busy    <= 1'b1;
            state       <= GRANT;
          end
        end
        GRANT: begin
          bus.req_rdy   <= '0;
          bus.m_cmd     <= cmd_reg;
          bus.m_cmd_vld <= 1'b1;
          state         <= ISSUE;
        end
        ISSUE: begin
          if (bus.m_cmd_rdy) begin
            bus.m_cmd     <= '0;
            bus.m_cmd_vld <= 1'b0;
            cnt           <= '0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (wait_done) begin
            bus.rsp_data <= is_rd ? bus.m_rd_data : '0;
            bus.rsp_err  <= 1'b0;
            bus.rsp_vld  <= onehot(gnt_idx);
            state        <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            bus.rsp_data <= '0;
            bus.rsp_err  <= 1'b1;
            bus.rsp_vld  <= onehot(gnt_idx);
            state        <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          bus.rsp_vld  <= '0;
          bus.rsp_data <= '0;
          bus.rsp_err  <= 1'b0;
          bus.busy     <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- N_REQ, 4, number of requesters.
- CMD_WIDTH, 12, command width; bit CMD_WIDTH-1 = 1 means read, 0 means write.
- READ_WIDTH, 8, read data width.
- TIMEOUT, 1023, maximum WAIT cycles before abort; counter width clog2(TIMEOUT+1).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, clock; all logic on the rising edge.
- rst_n, in, 1, reset, asynchronous, active-low.
- req_cmd, in, N_REQ*CMD_WIDTH, requester i command in slice [i*CMD_WIDTH +: CMD_WIDTH].
- req_vld, in, N_REQ, requester command valid.
- req_rdy, out, N_REQ, one-hot single-cycle command-accepted pulse.
- rsp_vld, out, N_REQ, one-hot single-cycle completion pulse.
- rsp_data, out, READ_WIDTH, read data; valid with rsp_vld.
- rsp_err, out, 1, timeout flag; valid with rsp_vld.
- m_cmd, out, CMD_WIDTH, command to the SPI master.
- m_cmd_vld, out, 1, command valid to the SPI master.
- m_cmd_rdy, in, 1, SPI master ready.
- m_done, in, 1, SPI master transaction-complete pulse.
- m_rd_vld, in, 1, SPI master read data valid.
- m_rd_data, in, READ_WIDTH, SPI master read data.
- busy, out, 1, high whenever state is not IDLE.

Function
REQ-003 FSM states SHALL be IDLE, GRANT, ISSUE, WAIT and RESP; encoding is free.
REQ-004 IDLE: when any req_vld bit is high, the next edge SHALL latch the round-robin winner into gnt_idx, the winner's req_cmd into cmd_reg and is_rd = cmd bit CMD_WIDTH-1, then go to GRANT.
REQ-005 Round-robin order SHALL search from index last+1 upward, wrapping modulo N_REQ.
REQ-006 last SHALL be updated to gnt_idx at every grant; its reset value is N_REQ-1, so requester 0 wins first.
REQ-007 GRANT lasts exactly 1 cycle and SHALL assert req_rdy[gnt_idx]; all other req_rdy bits stay 0; next state is ISSUE.
REQ-008 Requesters SHALL hold req_vld and req_cmd stable until req_rdy; the arbiter does not check this.
REQ-009 ISSUE SHALL drive m_cmd = cmd_reg and m_cmd_vld = 1 until the edge where m_cmd_rdy = 1, then go to WAIT. m_cmd_vld is 0 in all other states.
REQ-010 WAIT with is_rd = 1: m_rd_vld = 1 SHALL capture m_rd_data into the data register and go to RESP; m_done is ignored.
REQ-011 WAIT with is_rd = 0: m_done = 1 SHALL go to RESP with the data register cleared to 0.
REQ-012 WAIT timeout: a counter cleared on entry to WAIT SHALL increment each WAIT cycle; on reaching TIMEOUT with no completion, set err = 1, clear data to 0 and go to RESP. A completion in the same cycle SHALL take priority (err = 0).
REQ-013 RESP lasts exactly 1 cycle and SHALL assert rsp_vld[gnt_idx], rsp_data = data register and rsp_err = err; next state is IDLE.
REQ-014 rsp_data and rsp_err SHALL be 0 outside RESP.
REQ-015 m_done and m_rd_vld SHALL be ignored outside WAIT.
REQ-016 req_vld SHALL be sampled only in IDLE.
REQ-017 Latency: req_vld high in IDLE at cycle 0 gives req_rdy at cycle 1 and m_cmd_vld at cycle 2.
REQ-018 Latency: completion sampled at edge k gives rsp_vld during cycle k+1, and IDLE at cycle k+2.
REQ-019 Only one transaction SHALL be outstanding at any time.

Reset
REQ-020 On rst_n low, asynchronously: state = IDLE, gnt_idx = 0, last = N_REQ-1, cmd_reg = 0, data = 0, err = 0, counter = 0.
REQ-021 During and after reset: req_rdy = 0, rsp_vld = 0, rsp_data = 0, rsp_err = 0, m_cmd = 0, m_cmd_vld = 0, busy = 0.
REQ-022 Reset mid-transaction SHALL abandon the transaction with no rsp_vld; the SPI master shares rst_n.

Verification
REQ-023 Single write: req_vld[2] = 1 with cmd 0x0A5 and m_cmd_rdy = 1 -> req_rdy[2] at cycle 1, m_cmd = 0x0A5 with m_cmd_vld at cycle 2; m_done 5 cycles later -> rsp_vld[2], rsp_data = 0x00, rsp_err = 0.
REQ-024 Read: requester 1 cmd 0x8C3 -> on m_rd_vld with m_rd_data = 0x5A -> rsp_vld[1] with rsp_data = 0x5A, rsp_err = 0.
REQ-025 Fairness: all four req_vld held continuously -> grant order after reset is 0,1,2,3,0; no requester is granted twice while another is waiting.
REQ-026 Backpressure and timeout: m_cmd_rdy low for 10 cycles -> m_cmd_vld and m_cmd held stable throughout; then no m_done for TIMEOUT cycles -> rsp_vld with rsp_err = 1, rsp_data = 0, busy = 0 the following cycle.
REQ-027 Reset during WAIT -> all outputs 0 immediately and no rsp_vld; the next request from requester 0 is granted first.
